// File: rtl/ledscan_decode_if.sv
// LED scan observation bus: the driver presents LED, the decoder returns mode/position/status.
// Latency: none, plain wires between driver and decoder.
// Backpressure: none, LED is sampled every clock.
interface ledscan_decode_if;
    logic [3:0] LED;
    logic [1:0] DIR;
    logic       LOCKED;
    logic [1:0] POS;
    logic       STEP;
    logic       ERR;
    logic [7:0] ERRCNT;
    logic       STALL;

    // LED driver side: produces the scan pattern, observes the decode
    modport master (
        output LED,
        input  DIR, LOCKED, POS, STEP, ERR, ERRCNT, STALL
    );

    // Decoder side
    modport slave (
        input  LED,
        output DIR, LOCKED, POS, STEP, ERR, ERRCNT, STALL
    );
endinterface

// File: rtl/ledscan_decode.sv
// Recovers scan mode and lit position from a one-hot LED bus; flags illegal moves and stalls.
// Latency: STEP/ERR/DIR/LOCKED/POS update two rising edges after LED presents a new value.
// Backpressure: none, LED is sampled every clock and every change is evaluated.
module ledscan_decode #(
    parameter int LOCKN    = 3,
    parameter int STALLCYC = 33554432
) (
    input  logic             CLK,
    input  logic             RST_N,
    ledscan_decode_if.slave  bus
);
    localparam int SCW = $clog2(STALLCYC + 1);
    localparam int LCW = $clog2(LOCKN + 1);
    typedef logic [SCW-1:0] scnt_t;
    typedef logic [LCW-1:0] mcnt_t;
    localparam scnt_t STALL_TC = scnt_t'(STALLCYC);
    localparam mcnt_t LOCK_TC  = mcnt_t'(LOCKN);

    // Mask bit order follows the DIR code: bit0 BOTH, bit1 L2R, bit2 R2L
    logic [3:0] cur_q, prv_q;
    logic [2:0] mask_q, mask_nx;
    mcnt_t      mcnt_q, mcnt_nx;
    logic       first_q, first_nx;
    logic       sgn_vld_q, sgn_vld_nx;
    logic       sgn_up_q, sgn_up_nx;
    scnt_t      scnt_q, scnt_nx;
    logic [1:0] dir_q, dir_nx;
    logic       locked_q, locked_nx;
    logic [1:0] pos_q, pos_nx;
    logic       step_q, step_nx;
    logic       err_q, err_nx;
    logic [7:0] errcnt_q, errcnt_nx;
    logic       stall_q, stall_nx;

    logic       chg, onehot;
    logic [1:0] q;
    logic       up1, dn1, lin_up, lin_dn, both_ok;
    logic [2:0] cons, mnew;

    function automatic logic [1:0] dir_of(input logic [2:0] m);
        case (m)
            3'b001:  return 2'd0;
            3'b010:  return 2'd1;
            3'b100:  return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    // Move classification and next-state for mode tracking, stall and status outputs
    always_comb begin
        chg    = (prv_q != cur_q);
        onehot = (cur_q != 4'b0000) && ((cur_q & (cur_q - 4'd1)) == 4'b0000);
        case (cur_q)
            4'b0010: q = 2'd1;
            4'b0100: q = 2'd2;
            4'b1000: q = 2'd3;
            default: q = 2'd0;
        endcase

        // pos_q is the index of prv whenever a move is evaluated (first flag clear)
        up1    = (q == pos_q + 2'd1);
        dn1    = (q == pos_q - 2'd1);
        lin_up = up1 && (pos_q != 2'd3);
        lin_dn = dn1 && (pos_q != 2'd0);
        if (pos_q == 2'd3)
            both_ok = lin_dn;
        else if (pos_q == 2'd0)
            both_ok = lin_up;
        else
            both_ok = (lin_up || lin_dn) &&
                      (!sgn_vld_q || (sgn_up_q ? lin_up : lin_dn));
        cons = {up1, dn1, both_ok};
        mnew = mask_q & cons;

        mask_nx    = mask_q;
        mcnt_nx    = mcnt_q;
        first_nx   = first_q;
        sgn_vld_nx = sgn_vld_q;
        sgn_up_nx  = sgn_up_q;
        scnt_nx    = scnt_q;
        pos_nx     = pos_q;
        step_nx    = 1'b0;
        err_nx     = 1'b0;
        stall_nx   = stall_q;

        // A change always beats the stall terminal count
        if (chg) begin
            scnt_nx  = '0;
            stall_nx = 1'b0;
        end else if (scnt_q != STALL_TC) begin
            scnt_nx = scnt_q + scnt_t'(1);
            if (scnt_nx == STALL_TC) begin
                stall_nx   = 1'b1;
                mask_nx    = 3'b111;
                mcnt_nx    = '0;
                first_nx   = 1'b1;
                sgn_vld_nx = 1'b0;
            end
        end

        if (chg) begin
            if (!onehot) begin
                err_nx     = 1'b1;
                first_nx   = 1'b1;
                mask_nx    = 3'b111;
                mcnt_nx    = '0;
                sgn_vld_nx = 1'b0;
            end else if (first_q) begin
                pos_nx   = q;
                first_nx = 1'b0;
            end else if (cons == 3'b000) begin
                // Skip move: q becomes the new starting point
                err_nx     = 1'b1;
                pos_nx     = q;
                mask_nx    = 3'b111;
                mcnt_nx    = '0;
                sgn_vld_nx = 1'b0;
            end else if (mnew == 3'b000) begin
                // Mode changed: restart tracking from this move alone
                err_nx     = 1'b1;
                pos_nx     = q;
                mask_nx    = cons;
                mcnt_nx    = mcnt_t'(1);
                sgn_vld_nx = lin_up || lin_dn;
                sgn_up_nx  = lin_up;
            end else begin
                step_nx    = 1'b1;
                pos_nx     = q;
                mask_nx    = mnew;
                mcnt_nx    = (mcnt_q == LOCK_TC) ? mcnt_q : mcnt_q + mcnt_t'(1);
                sgn_vld_nx = lin_up || lin_dn;
                sgn_up_nx  = lin_up;
            end
        end

        errcnt_nx = (err_nx && errcnt_q != 8'd255) ? errcnt_q + 8'd1 : errcnt_q;
        dir_nx    = dir_of(mask_nx);
        locked_nx = (dir_nx != 2'd3) && (mcnt_nx >= LOCK_TC);
    end

    // Sample LED and register all state and outputs; reset discards all history
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cur_q     <= 4'b0000;
            prv_q     <= 4'b0000;
            mask_q    <= 3'b111;
            mcnt_q    <= '0;
            first_q   <= 1'b1;
            sgn_vld_q <= 1'b0;
            sgn_up_q  <= 1'b0;
            scnt_q    <= '0;
            dir_q     <= 2'd3;
            locked_q  <= 1'b0;
            pos_q     <= 2'd0;
            step_q    <= 1'b0;
            err_q     <= 1'b0;
            errcnt_q  <= 8'd0;
            stall_q   <= 1'b0;
        end else begin
            cur_q     <= bus.LED;
            prv_q     <= cur_q;
            mask_q    <= mask_nx;
            mcnt_q    <= mcnt_nx;
            first_q   <= first_nx;
            sgn_vld_q <= sgn_vld_nx;
            sgn_up_q  <= sgn_up_nx;
            scnt_q    <= scnt_nx;
            dir_q     <= dir_nx;
            locked_q  <= locked_nx;
            pos_q     <= pos_nx;
            step_q    <= step_nx;
            err_q     <= err_nx;
            errcnt_q  <= errcnt_nx;
            stall_q   <= stall_nx;
        end
    end

    assign bus.DIR    = dir_q;
    assign bus.LOCKED = locked_q;
    assign bus.POS    = pos_q;
    assign bus.STEP   = step_q;
    assign bus.ERR    = err_q;
    assign bus.ERRCNT = errcnt_q;
    assign bus.STALL  = stall_q;
endmodule

// File: doc/ledscan_decode.md
Name: ledscan_decode

Overview:
- Decoder for the 4-bit one-hot LED scan bus driven by the direction-blink logic.
- Watches the pattern on LED and recovers the scan mode (bounce, right-to-left, left-to-right) and the current lit position.
- Flags illegal transitions and stalls.
- Used as an on-board self-check and as the observation point for bench checks of the LED driver.

Parameters:
- LOCKN, 3: consecutive consistent moves required before LOCKED asserts.
- STALLCYC, 33554432: CLK cycles without an LED change before STALL asserts; 26-bit counter; bench overrides to 64.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RST_N  input  1  synchronous reset, active low.
- LED  input  4  observed LED bus, same clock domain; legal values are one-hot.
- DIR  output  2  0 = BOTH (bounce), 1 = L2R, 2 = R2L, 3 = unknown.
- LOCKED  output  1  DIR is valid and stable.
- POS  output  2  index of the lit LED (0 = LED[0]), last valid value.
- STEP  output  1  one-cycle pulse per legal one-hot change.
- ERR  output  1  one-cycle pulse per illegal pattern or illegal move.
- ERRCNT  output  8  ERR pulse count, saturating at 255.
- STALL  output  1  no LED change for STALLCYC cycles.

Behaviour:
- Reset (RST_N = 0 at a rising edge):
  - Outputs: DIR = 3, LOCKED = 0, POS = 0, STEP = 0, ERR = 0, ERRCNT = 0, STALL = 0.
  - Internal: sample registers cleared, candidate mask = 3'b111, move count = 0, first-sample flag set, stall counter = 0.
  - Reset applied mid-operation discards all history.
- Sampling and latency:
  - LED is registered into cur; the previous cur is held in prv.
  - A change is prv != cur.
  - STEP and ERR are registered: they assert two rising edges after the edge at which LED first presents the new value.
- Invalid pattern (cur not one-hot, including 4'b0000):
  - ERR pulses; POS holds.
  - First-sample flag set, mask = 3'b111, count = 0, DIR = 3, LOCKED = 0.
- First valid sample after reset or invalid:
  - POS loaded, no move evaluated, no STEP; first-sample flag cleared.
- Move p -> q, both one-hot, not first sample:
  - R2L is consistent iff q == p+1 mod 4.
  - L2R is consistent iff q == p-1 mod 4.
  - BOTH is consistent iff |q-p| == 1 without wrap, and:
    - p == 3 requires a down move;
    - p == 0 requires an up move;
    - for 1 <= p <= 2, the sign must equal the previous move's sign, when that sign is known.
- Move consistent with none of the three (skip by 2, e.g. 0001 -> 0100):
  - ERR pulses, POS = q.
  - Treated as a first sample: mask = 3'b111, count = 0, previous sign unknown.
- Move consistent with at least one mode but with no mode left in the mask:
  - ERR pulses, POS = q.
  - mask = consistent set of this move alone, count = 1.
- Otherwise:
  - STEP pulses, POS = q, mask &= consistent set.
  - count increments, saturating at LOCKN.
  - Previous sign updated.
- DIR and LOCKED:
  - DIR = the single set mask bit when exactly one bit is set, else 3.
  - LOCKED = (exactly one mask bit set) and (count >= LOCKN).
  - Both update on the same edge as STEP/ERR.
- Stall counter:
  - Clears on any change; otherwise increments and saturates at STALLCYC.
  - On reaching STALLCYC: STALL = 1, LOCKED = 0, DIR = 3, mask = 3'b111, count = 0, first-sample flag set.
  - STALL clears on the next change; that change is treated as a first sample.
  - A change and a stall terminal count in the same cycle: the change wins.
- ERRCNT increments on every ERR pulse and holds at 255.

Test Plan:
- Bounce: reset, LED = 0001, 0010, 0100, 1000, 0100, 0010, each held 8 cycles.
  - Expect 5 STEP pulses.
  - DIR = 3 until the 1000 -> 0100 move, then DIR = 0 and LOCKED = 1 on that same edge.
  - POS = 1 at the end; ERR never asserts.
- R2L: LED = 0001, 0010, 0100, 1000, 0001.
  - Expect DIR = 2 and LOCKED = 1 at the 3 -> 0 move; POS = 0.
- L2R: LED = 1000, 0100, 0010, 0001, 1000.
  - Expect DIR = 1 and LOCKED = 1 at the 0 -> 3 move.
  - Then drive 0100: one STEP, still locked.
- Errors:
  - Once locked in BOTH, drive 0010 -> 1000 (skip): ERR pulse, LOCKED = 0, DIR = 3, ERRCNT = 1.
  - Then drive 0000: second ERR, ERRCNT = 2, POS holds 3.
- Mode change: locked R2L at POS 3, drive 0100 (down move).
  - ERR pulse, mask = {BOTH, L2R}, DIR = 3.
  - Then drive 0010, 0001, 1000: DIR = 1, LOCKED = 1 after the 0 -> 3 move.
- Stall and reset: STALLCYC = 64, locked in any mode, hold LED constant.
  - STALL = 1 and LOCKED = 0 exactly 64 cycles after the last change.
  - Next change: STALL = 0, no STEP.
  - Drive RST_N low 1 cycle mid-scan: all outputs return to reset values, including ERRCNT = 0.
